touch_adc_responder: RTL
========================

# touch_adc_responder

Behavioural responder for the four-wire touchscreen ADC serial interface (ADS7843-style: TP_CS, TP_DCLK, DIN, DOUT, busy, interrupt). It sits on the far side of the touch pins from the host-side axis/touch logic. It decodes the 8-bit control byte, returns a 12-bit or 8-bit X/Y sample and models the pen interrupt. It is used as a bench target and as a loopback target on the board. All logic runs on the system clock; TP_DCLK is oversampled, not used as a clock.

## Interface
- SYNC_STAGES, 2, synchronizer depth on TP_CS, TP_DCLK and DIN (minimum 2)
- X_CHAN, 3'b001, A2..A0 code that selects x_sample
- Y_CHAN, 3'b101, A2..A0 code that selects y_sample

- Clk  in  1  system clock (50 MHz); the only clock
- rst  in  1  asynchronous, active-high reset
- TP_CS  in  1  chip select from host, active low
- TP_DCLK  in  1  serial clock from host; host samples DOUT on its rising edge
- DIN  in  1  control bits from host, sampled on TP_DCLK rising edge
- DOUT  out  1  conversion data, MSB first, updated on TP_DCLK falling edge
- busy  out  1  conversion-in-progress strobe
- interrupt  out  1  pen interrupt, active low
- pen_down  in  1  stimulus: pen touching panel
- x_sample  in  12  stimulus: X conversion value
- y_sample  in  12  stimulus: Y conversion value

## Operation
- Synchronized TP_DCLK is edge-detected against its previous synchronized value. This gives one-Clk rise and fall pulses. DIN is taken from the same synchronizer stage as TP_DCLK.
- Control byte bits, first to last: S, A2, A1, A0, MODE (1 = 8-bit), SER/DFR (ignored), PD1 (ignored), PD0.
- The FSM has five states: HUNT, CTRL, CONV, DATA, DONE.
- HUNT: on a rise with CS low and DIN=1, go to CTRL with bit count 1. Rises with DIN=0 are leading zeros and are ignored.
- CTRL: shift DIN on each rise. After the 8th bit:
  - latch channel, MODE and PD0;
  - snapshot the selected sample: X_CHAN gives x_sample, Y_CHAN gives y_sample, any other code gives 12'h000;
  - go to CONV.
- CONV: on the next fall, assert busy. On the following fall, deassert busy, drive bit 11 and go to DATA.
- DATA: on each later fall, drive the next lower bit.
  - 12-bit mode: bits 11..0.
  - 8-bit mode: bits 11..4.
  - The fall after the LSB drives DOUT=0 and goes to DONE.
- DONE: DOUT=0. Behaves as HUNT: a start bit begins a new cycle. Overlapped control bytes during DATA are not supported; DIN is ignored outside HUNT, DONE and CTRL.
- TP_CS high (synchronized), from any state: go to HUNT next Clk, with busy=0 and DOUT=0. No partial data is retained.
- PD0 latch: reset value 0, updated only at a complete control byte.
- interrupt = ~(pen_down & ~PD0), registered; see Configuration.

## Timing
- Reset values:
  - DOUT=0, busy=0, interrupt=1;
  - state HUNT, PD0 latch 0, MODE 0, sample register 0.
- Pin-to-response latency: SYNC_STAGES+1 Clk from a TP_DCLK or TP_CS pin edge to the DOUT, busy or state change.
- Input requirement: TP_DCLK high and low phases each ≥ SYNC_STAGES+3 Clk. At 1.56 MHz there are ~16 Clk per phase.
- Full cycle on the pins:
  - control bits sampled on host rises 1..8;
  - busy high from fall 8 to fall 9;
  - data MSB valid before rise 10;
  - 12-bit LSB captured by the host on rise 21, 8-bit LSB on rise 17.
- Simultaneous CS deassert and DCLK edge in the same Clk: CS wins; the edge is discarded.
- Sample inputs are read only at the 8th rise. Changes to them afterwards do not affect the current cycle.
- interrupt: pen_down is registered once; latency 1 Clk from pen_down or PD0 latch change. A reset mid-operation takes effect immediately (asynchronously).

## Configuration
- TOUCH_RESP_PENIRQ_EN defined: interrupt is modelled as above.
- TOUCH_RESP_PENIRQ_EN undefined: interrupt is held constant 1; the PD0 latch and pen_down register are removed. pen_down is unused.
- All serial behaviour is identical in both builds.

## Test plan
- X read, 12-bit:
  - Stimulus: x_sample=12'hA5C, host sends 8'b1001_0000 then 16 clocks.
  - Required: busy high for exactly one DCLK period after rise 8; host receives 12'hA5C; DOUT=0 afterwards.
- Y read, 8-bit:
  - Stimulus: y_sample=12'h3F7, control 8'b1101_1000.
  - Required: host receives 8'h3F over 8 rises; DOUT=0 on the next fall.
- Leading zeros and unknown channel:
  - Stimulus: three zero bits, then 8'b1010_0000 (channel 010).
  - Required: cycle starts on the fourth rise; data is 12'h000.
- CS abort:
  - Stimulus: TP_CS raised after the 5th data bit of an X read, then a fresh X read.
  - Required: busy=0 and DOUT=0 within SYNC_STAGES+1 Clk; the second read returns the full correct value.
- PENIRQ (with TOUCH_RESP_PENIRQ_EN):
  - Stimulus: pen_down=1 with PD0=0; then a control byte with PD0=1.
  - Required: interrupt=0 in the first case; interrupt=1 one Clk after the 8th rise, despite pen_down=1.
- Reset mid-DATA:
  - Stimulus: assert rst during bit 6.
  - Required: DOUT=0, busy=0 and interrupt=1 immediately; after release, the next start bit is decoded normally.

Source files
------------

// File: rtl/touch_adc_responder.sv
// Far-end model of an ADS7843-style touch ADC: decodes the control byte, serialises an X/Y sample, models the pen IRQ.
// Optional pen interrupt model is enabled by TOUCH_RESP_PENIRQ_EN; without it interrupt is tied high.
module touch_adc_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [2:0] X_CHAN      = 3'b001,
  parameter logic [2:0] Y_CHAN      = 3'b101
) (
  input  logic        Clk,
  input  logic        rst,
  input  logic        TP_CS,
  input  logic        TP_DCLK,
  input  logic        DIN,
  output logic        DOUT,
  output logic        busy,
  output logic        interrupt,
  input  logic        pen_down,
  input  logic [11:0] x_sample,
  input  logic [11:0] y_sample
);

  typedef enum logic [2:0] {HUNT, CTRL, CONV, DATA, DONE} state_t;

  logic [SYNC_STAGES-1:0] cs_sync, dclk_sync, din_sync;
  logic                   dclk_prev;
  logic                   cs_s, din_s, rise, fall;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [5:0]  sh, sh_n;
  logic        mode, mode_n;
  logic [11:0] samp, samp_n;
  logic        busy_n, dout_n;
  logic        pd0, pd0_n;
  logic        unused_ctrl;

  assign cs_s  = cs_sync[SYNC_STAGES-1];
  assign din_s = din_sync[SYNC_STAGES-1];
  assign rise  = dclk_sync[SYNC_STAGES-1] & ~dclk_prev;
  assign fall  = ~dclk_sync[SYNC_STAGES-1] & dclk_prev;
  // SER/DFR and PD1 are shifted in but have no effect on this model
  assign unused_ctrl = ^sh[1:0];

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      cs_sync   <= '1;
      dclk_sync <= '0;
      din_sync  <= '0;
      dclk_prev <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], TP_CS};
      dclk_sync <= {dclk_sync[SYNC_STAGES-2:0], TP_DCLK};
      din_sync  <= {din_sync[SYNC_STAGES-2:0], DIN};
      dclk_prev <= dclk_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state <= HUNT;
      cnt   <= 4'd0;
      sh    <= 6'd0;
      mode  <= 1'b0;
      samp  <= 12'h000;
      busy  <= 1'b0;
      DOUT  <= 1'b0;
      pd0   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sh    <= sh_n;
      mode  <= mode_n;
      samp  <= samp_n;
      busy  <= busy_n;
      DOUT  <= dout_n;
      pd0   <= pd0_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    mode_n  = mode;
    samp_n  = samp;
    busy_n  = busy;
    dout_n  = DOUT;
    pd0_n   = pd0;
    // Deselect overrides any coincident DCLK edge
    if (cs_s) begin
      state_n = HUNT;
      busy_n  = 1'b0;
      dout_n  = 1'b0;
    end else begin
      case (state)
        HUNT, DONE: begin
          dout_n = 1'b0;
          if (rise && din_s) begin
            state_n = CTRL;
            cnt_n   = 4'd1;
          end
        end
        CTRL: begin
          if (rise) begin
            if (cnt == 4'd7) begin
              mode_n  = sh[2];
              pd0_n   = din_s;
              if (sh[5:3] == X_CHAN)      samp_n = x_sample;
              else if (sh[5:3] == Y_CHAN) samp_n = y_sample;
              else                        samp_n = 12'h000;
              busy_n  = 1'b0;
              cnt_n   = 4'd0;
              state_n = CONV;
            end else begin
              sh_n  = {sh[4:0], din_s};
              cnt_n = cnt + 4'd1;
            end
          end
        end
        CONV: begin
          if (fall) begin
            if (!busy) begin
              busy_n = 1'b1;
            end else begin
              busy_n  = 1'b0;
              dout_n  = samp[11];
              samp_n  = {samp[10:0], 1'b0};
              cnt_n   = 4'd1;
              state_n = DATA;
            end
          end
        end
        DATA: begin
          // cnt holds the number of bits already driven
          if (fall) begin
            if (cnt == (mode ? 4'd8 : 4'd12)) begin
              dout_n  = 1'b0;
              state_n = DONE;
            end else begin
              dout_n = samp[11];
              samp_n = {samp[10:0], 1'b0};
              cnt_n  = cnt + 4'd1;
            end
          end
        end
        default: state_n = HUNT;
      endcase
    end
  end

`ifdef TOUCH_RESP_PENIRQ_EN
  always_ff @(posedge Clk or posedge rst) begin
    if (rst) interrupt <= 1'b1;
    else     interrupt <= ~(pen_down & ~pd0);
  end
`else
  logic unused_pen;
  logic unused_pd0;
  assign unused_pen = pen_down;
  assign unused_pd0 = pd0;
  assign interrupt  = 1'b1;
`endif

endmodule
